// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES key-schedule definitions: controller state type,
//               round-constant table, S-box and the SubWord / RotWord / xtime
//               helpers used by the word generator.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

  typedef enum logic [1:0] {
    KS_IDLE   = 2'd0,
    KS_EXPAND = 2'd1,
    KS_READY  = 2'd2,
    KS_ZERO   = 2'd3
  } ks_state_t;

  // Round constants Rcon[1..10]. Only the first is loaded; later ones are
  // produced by xtime so the generator needs no table lookup per key.
  localparam logic [79:0] c_rcon_tbl   = 80'h01020408102040801b36;
  localparam logic [7:0]  c_rcon_first = c_rcon_tbl[79:72];

  // Forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] c_sbox = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] lsb;
    lsb = 11'd2040 - {b, 3'b000};
    return c_sbox[lsb +: 8];
  endfunction

  // Word byte order: first byte (a0) in bits [31:24].
  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] x);
    return {x[23:0], x[31:24]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_key_word_gen.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_word_gen
// Description : Combinational AES key-expansion step
//               w[i] = w[i-Nk] ^ f(w[i-1]). A single SubWord (four S-boxes)
//               is shared between the RotWord and plain-SubWord cases.
// Ports       : w_nk   in  32  w[i-Nk]
//               w_prev in  32  w[i-1]
//               i_mod  in  3   i mod Nk
//               rcon   in  8   current round constant
//               w_out  out 32  w[i]
// Revision    : 1.0 - initial release
// ============================================================================
module aes_key_word_gen
  import aes_pkg::*;
#(
  parameter int NK = 4
) (
  input  logic [31:0] w_nk,
  input  logic [31:0] w_prev,
  input  logic [2:0]  i_mod,
  input  logic [7:0]  rcon,
  output logic [31:0] w_out
);

  logic        w_rot_sel;
  logic        w_sub_sel;
  logic [31:0] w_sub_in;
  logic [31:0] w_sub_out;
  logic [31:0] w_f;

  assign w_rot_sel = (i_mod == 3'd0);

  // 256-bit keys add a plain SubWord half way through each key-length block.
  generate
    if (NK > 6) begin : g_nk_long
      assign w_sub_sel = (i_mod == 3'd4);
    end else begin : g_nk_short
      assign w_sub_sel = 1'b0;
    end
  endgenerate

  assign w_sub_in  = w_rot_sel ? rot_word(w_prev) : w_prev;
  assign w_sub_out = sub_word(w_sub_in);

  // Rcon lands in the first (most significant) byte of the word.
  always_comb begin
    w_f = w_prev;
    if (w_rot_sel) begin
      w_f = w_sub_out ^ {rcon, 24'h000000};
    end else if (w_sub_sel) begin
      w_f = w_sub_out;
    end
  end

  assign w_out = w_nk ^ w_f;

endmodule
`default_nettype wire

// File: rtl/aes_key_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_sched_ctrl
// Description : Iterative AES key-schedule controller. Accepts a cipher key,
//               expands one word per cycle into a 4*(Nr+1)-word store and
//               serves 128-bit round keys on request.
// Options     : AES_KEY_ZEROIZE_EN - adds the zeroize input and the ZERO
//               state that sweeps the store, window and rcon to zero.
// Ports       : clk        in   1      clock
//               rst_b      in   1      asynchronous active-low reset
//               key_valid  in   1      key offer
//               key_ready  out  1      key can be accepted (IDLE/READY)
//               key        in   32*NK  cipher key, key[32*i+:32] = w[i]
//               keys_valid out  1      complete schedule present
//               rk_req     in   1      round-key read request
//               rk_idx     in   4      round number 0..NR
//               zeroize    in   1      (option) wipe key material
//               rk_valid   out  1      read response strobe
//               rk_err     out  1      read rejected (with rk_valid)
//               rk         out  128    {w[4r+3],w[4r+2],w[4r+1],w[4r]}
// Revision    : 1.0 - initial release
// ============================================================================
module aes_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int NK = 4,
  parameter int NR = NK + 6
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            key_valid,
  output logic            key_ready,
  input  logic [32*NK-1:0] key,
  output logic            keys_valid,
  input  logic            rk_req,
  input  logic [3:0]      rk_idx,
`ifdef AES_KEY_ZEROIZE_EN
  input  logic            zeroize,
`endif
  output logic            rk_valid,
  output logic            rk_err,
  output logic [127:0]    rk
);

  localparam int NW   = 4 * (NR + 1);
  localparam int c_iw = $clog2(NW + 1);
  localparam logic [c_iw-1:0] c_last = c_iw'(NW - 1);
  localparam logic [c_iw-1:0] c_nw   = c_iw'(NW);

  ks_state_t        r_state;
  ks_state_t        w_state_nxt;

  logic [31:0]      r_store [NW];
  logic [32*NK-1:0] r_win;        // last NK words, oldest in the low word
  logic [c_iw-1:0]  r_idx;        // word being written (EXPAND) or wiped (ZERO)
  logic [2:0]       r_imod;       // r_idx mod NK, tracked without a divider
  logic [7:0]       r_rcon;
  logic             r_keys_valid;
  logic             r_rk_valid;
  logic             r_rk_err;
  logic [127:0]     r_rk;

  logic             w_zeroize;
  logic             w_key_ready;
  logic             w_accept;
  logic [31:0]      w_new;
  logic             w_rd_err;
  logic [127:0]     w_rd_data;

`ifdef AES_KEY_ZEROIZE_EN
  assign w_zeroize = zeroize;
`else
  assign w_zeroize = 1'b0;
`endif

  assign w_key_ready = (r_state == KS_IDLE) || (r_state == KS_READY);
  // Zeroize wins over a key offered in the same cycle.
  assign w_accept    = key_valid && w_key_ready && !w_zeroize;

  aes_key_word_gen #(
    .NK (NK)
  ) u_word_gen (
    .w_nk   (r_win[31:0]),
    .w_prev (r_win[32*NK-1 -: 32]),
    .i_mod  (r_imod),
    .rcon   (r_rcon),
    .w_out  (w_new)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= KS_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      KS_IDLE, KS_READY: begin
        if (w_accept) begin
          w_state_nxt = KS_EXPAND;
        end
      end
      KS_EXPAND: begin
        if (r_idx == c_last) begin
          w_state_nxt = KS_READY;
        end
      end
      KS_ZERO: begin
        if (r_idx == c_nw) begin
          w_state_nxt = KS_IDLE;
        end
      end
      default: w_state_nxt = KS_IDLE;
    endcase
    if (w_zeroize) begin
      w_state_nxt = KS_ZERO;
    end
  end

  // ------------------------------------------------- counters and window
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_idx        <= '0;
      r_imod       <= '0;
      r_rcon       <= '0;
      r_win        <= '0;
      r_keys_valid <= 1'b0;
    end else begin
      // One cycle behind READY so the last store write has settled.
      r_keys_valid <= (r_state == KS_READY) && !w_accept && !w_zeroize;
      if (w_zeroize) begin
        r_idx <= '0;
      end else if (w_accept) begin
        r_idx  <= c_iw'(NK);
        r_imod <= '0;
        r_rcon <= c_rcon_first;
        r_win  <= key;
      end else begin
        case (r_state)
          KS_EXPAND: begin
            r_idx  <= r_idx + c_iw'(1);
            r_imod <= (r_imod == 3'(NK - 1)) ? 3'd0 : r_imod + 3'd1;
            if (r_imod == 3'd0) begin
              r_rcon <= xtime(r_rcon);
            end
            r_win  <= {w_new, r_win[32*NK-1:32]};
          end
          KS_ZERO: begin
            if (r_idx != c_nw) begin
              r_idx <= r_idx + c_iw'(1);
            end else begin
              r_idx  <= '0;
              r_imod <= '0;
              r_rcon <= '0;
              r_win  <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------------------------------------------------- word store
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int k = 0; k < NW; k++) begin
        r_store[k] <= '0;
      end
    end else if (!w_zeroize) begin
      if (w_accept) begin
        for (int k = 0; k < NK; k++) begin
          r_store[k] <= key[32*k +: 32];
        end
      end else if (r_state == KS_EXPAND) begin
        r_store[r_idx] <= w_new;
      end else if ((r_state == KS_ZERO) && (r_idx != c_nw)) begin
        r_store[r_idx] <= '0;
      end
    end
  end

  // ----------------------------------------------------------- read port
  // Sampled from the current store, so a key accepted on the same edge
  // does not affect the response.
  assign w_rd_err = !r_keys_valid || (rk_idx > 4'(NR));

  always_comb begin
    w_rd_data = '0;
    for (int r = 0; r <= NR; r++) begin
      if (rk_idx == 4'(r)) begin
        w_rd_data = {r_store[4*r+3], r_store[4*r+2], r_store[4*r+1], r_store[4*r]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_rk_valid <= 1'b0;
      r_rk_err   <= 1'b0;
      r_rk       <= '0;
    end else if (rk_req) begin
      r_rk_valid <= 1'b1;
      r_rk_err   <= w_rd_err;
      r_rk       <= w_rd_err ? '0 : w_rd_data;
    end else begin
      r_rk_valid <= 1'b0;
      r_rk_err   <= 1'b0;
    end
  end

  assign key_ready  = w_key_ready;
  assign keys_valid = r_keys_valid;
  assign rk_valid   = r_rk_valid;
  assign rk_err     = r_rk_err;
  assign rk         = r_rk;

endmodule
`default_nettype wire

// File: tb/tb_aes_key_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_key_sched_ctrl
// Description : Directed bench for aes_key_sched_ctrl using FIPS-197 A.1
//               (128-bit), A.3 (256-bit) and the all-zero 128-bit key.
//               Covers latency, read errors, same-cycle reload, async reset
//               and (with AES_KEY_ZEROIZE_EN) zeroization.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_key_sched_ctrl;

  localparam logic [127:0] A1_KEY  = {32'h09cf4f3c, 32'habf71588, 32'h28aed2a6, 32'h2b7e1516};
  localparam logic [127:0] A1_RK1  = {32'h2a6c7605, 32'h23a33939, 32'h88542cb1, 32'ha0fafe17};
  localparam logic [127:0] A1_RK10 = {32'hb6630ca6, 32'he13f0cc8, 32'hc9ee2589, 32'hd014f9a8};
  localparam logic [127:0] Z_RK1   = {4{32'h62636363}};
  localparam logic [127:0] Z_RK10  = {32'h6f8f188e, 32'h23e951cf, 32'h3e92e211, 32'hb4ef5bcb};
  localparam logic [255:0] A3_KEY  = {32'h0914dff4, 32'h2d9810a3, 32'h3b6108d7, 32'h1f352c07,
                                      32'h857d7781, 32'h2b73aef0, 32'h15ca71be, 32'h603deb10};
  localparam logic [127:0] A3_RK14 = {32'h706c631e, 32'h046df344, 32'he6188d0b, 32'hfe4890d1};

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_b;

  logic         kv4, kr4, kval4, req4, rkv4, rke4;
  logic [127:0] key4, rk4;
  logic [3:0]   idx4;
  logic         kv8, kr8, kval8, req8, rkv8, rke8;
  logic [255:0] key8;
  logic [127:0] rk8;
  logic [3:0]   idx8;
`ifdef AES_KEY_ZEROIZE_EN
  logic         zero4, zero8;
`endif

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;
  int cnt;

  aes_key_sched_ctrl #(.NK(4)) u_dut4 (
    .clk        (clk),
    .rst_b      (rst_b),
    .key_valid  (kv4),
    .key_ready  (kr4),
    .key        (key4),
    .keys_valid (kval4),
    .rk_req     (req4),
    .rk_idx     (idx4),
`ifdef AES_KEY_ZEROIZE_EN
    .zeroize    (zero4),
`endif
    .rk_valid   (rkv4),
    .rk_err     (rke4),
    .rk         (rk4)
  );

  aes_key_sched_ctrl #(.NK(8)) u_dut8 (
    .clk        (clk),
    .rst_b      (rst_b),
    .key_valid  (kv8),
    .key_ready  (kr8),
    .key        (key8),
    .keys_valid (kval8),
    .rk_req     (req8),
    .rk_idx     (idx8),
`ifdef AES_KEY_ZEROIZE_EN
    .zeroize    (zero8),
`endif
    .rk_valid   (rkv8),
    .rk_err     (rke8),
    .rk         (rk8)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd4(input logic [3:0] i);
    req4 = 1'b1;
    idx4 = i;
    step();
    req4 = 1'b0;
  endtask

  task automatic rd8(input logic [3:0] i);
    req8 = 1'b1;
    idx8 = i;
    step();
    req8 = 1'b0;
  endtask

  // Counts cycles after the accept edge until keys_valid rises (bounded).
  task automatic wait_kv4(input int start, output int c);
    c = start;
    while (kval4 !== 1'b1 && c < 200) begin
      step();
      c++;
    end
  endtask

  task automatic wait_kv8(input int start, output int c);
    c = start;
    while (kval8 !== 1'b1 && c < 200) begin
      step();
      c++;
    end
  endtask

  initial begin
    rst_b = 1'b0;
    kv4 = 1'b0; key4 = '0; req4 = 1'b0; idx4 = '0;
    kv8 = 1'b0; key8 = '0; req8 = 1'b0; idx8 = '0;
`ifdef AES_KEY_ZEROIZE_EN
    zero4 = 1'b0; zero8 = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst_b = 1'b1;
    step();

    // Reset state
    chk("rst_key_ready",  128'(kr4),   128'(1));
    chk("rst_keys_valid", 128'(kval4), 128'(0));
    chk("rst_rk_valid",   128'(rkv4),  128'(0));
    chk("rst_rk_err",     128'(rke4),  128'(0));
    chk("rst_rk",         rk4,         128'(0));

    // 256-bit schedule (A.3)
    kv8 = 1'b1; key8 = A3_KEY;
    step();
    kv8 = 1'b0;
    wait_kv8(0, cnt);
    chk("a3_latency", 128'(cnt), 128'(53));
    rd8(4'd14);
    chk("a3_rk14_valid", 128'(rkv8), 128'(1));
    chk("a3_rk14_err",   128'(rke8), 128'(0));
    chk("a3_rk14",       rk8,        A3_RK14);
    rd8(4'd15);
    chk("a3_idx15_err", 128'(rke8), 128'(1));
    chk("a3_idx15_rk",  rk8,        128'(0));

    // 128-bit schedule (A.1) with a read while expanding
    kv4 = 1'b1; key4 = A1_KEY;
    step();
    kv4 = 1'b0;
    chk("exp_key_ready", 128'(kr4), 128'(0));
    rd4(4'd0);
    chk("exp_rd_valid", 128'(rkv4), 128'(1));
    chk("exp_rd_err",   128'(rke4), 128'(1));
    chk("exp_rd_rk",    rk4,        128'(0));
    step();
    chk("exp_rd_strobe_once", 128'(rkv4), 128'(0));
    chk("exp_err_clears",     128'(rke4), 128'(0));
    wait_kv4(2, cnt);
    chk("a1_latency",     128'(cnt), 128'(41));
    chk("a1_ready_again", 128'(kr4), 128'(1));
    rd4(4'd0);
    chk("a1_rk0", rk4, A1_KEY);
    rd4(4'd1);
    chk("a1_rk1", rk4, A1_RK1);
    rd4(4'd10);
    chk("a1_rk10_err", 128'(rke4), 128'(0));
    chk("a1_rk10",     rk4,        A1_RK10);
    step();
    chk("a1_hold_valid", 128'(rkv4), 128'(0));
    chk("a1_hold_rk",    rk4,        A1_RK10);
    rd4(4'd11);
    chk("a1_idx11_valid", 128'(rkv4), 128'(1));
    chk("a1_idx11_err",   128'(rke4), 128'(1));
    chk("a1_idx11_rk",    rk4,        128'(0));
    chk("a1_idx11_fsm",   128'(kval4), 128'(1));

    // Reload in READY with a same-cycle read: old schedule answers
    kv4 = 1'b1; key4 = '0; req4 = 1'b1; idx4 = 4'd0;
    step();
    kv4 = 1'b0; req4 = 1'b0;
    chk("reload_rd_err", 128'(rke4),  128'(0));
    chk("reload_rd_old", rk4,         A1_KEY);
    chk("reload_kv_low", 128'(kval4), 128'(0));
    wait_kv4(0, cnt);
    chk("zero_latency", 128'(cnt), 128'(41));
    rd4(4'd10);
    chk("zero_rk10", rk4, Z_RK10);
    rd4(4'd1);
    chk("zero_rk1", rk4, Z_RK1);

    // Asynchronous reset in the middle of expansion
    kv4 = 1'b1; key4 = A1_KEY;
    step();
    kv4 = 1'b0;
    repeat (20) step();
    chk("mid_in_expand", 128'(kr4), 128'(0));
    #2;
    rst_b = 1'b0;
    #1;
    chk("arst_key_ready",  128'(kr4),   128'(1));
    chk("arst_keys_valid", 128'(kval4), 128'(0));
    chk("arst_rk_valid",   128'(rkv4),  128'(0));
    chk("arst_rk_err",     128'(rke4),  128'(0));
    chk("arst_rk",         rk4,         128'(0));
    #1;
    rst_b = 1'b1;
    step();
    kv4 = 1'b1; key4 = A1_KEY;
    step();
    kv4 = 1'b0;
    wait_kv4(0, cnt);
    chk("reload_latency", 128'(cnt), 128'(41));
    rd4(4'd10);
    chk("reload_rk10", rk4, A1_RK10);

`ifdef AES_KEY_ZEROIZE_EN
    // Zeroize from READY
    zero4 = 1'b1;
    step();
    zero4 = 1'b0;
    chk("zz_key_ready",  128'(kr4),   128'(0));
    chk("zz_keys_valid", 128'(kval4), 128'(0));
    cnt = 0;
    while (kr4 !== 1'b1 && cnt < 200) begin
      step();
      cnt++;
    end
    chk("zz_duration", 128'(cnt), 128'(45));
    rd4(4'd0);
    chk("zz_rd_err", 128'(rke4), 128'(1));
    chk("zz_rd_rk",  rk4,        128'(0));
    begin
      logic acc;
      acc = 1'b0;
      for (int k = 0; k < 44; k++) begin
        acc = acc | (|u_dut4.r_store[k]);
      end
      chk("zz_store_clear", 128'(acc), 128'(0));
    end
    chk("zz_window_clear", u_dut4.r_win, 128'(0));
    chk("zz_rcon_clear",   128'(u_dut4.r_rcon), 128'(0));
`endif

    if (n_fail != 0) begin
      $display("%0d comparison(s) did not match", n_fail);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
